// File: rtl/rgb_fade_sequencer_if.sv
// Bundle of the sequencer's control input and LED/duty/phase outputs.
//   enable      : 1 = sequencing runs, 0 = freeze duties and timebase
//   led_r/g/b   : active-high PWM drives
//   duty_r/g/b  : current per-channel duty registers, 0..PWM_INTERVAL
//   phase       : current colour-wheel phase, 0..5
//   phase_done  : one-cycle pulse while a newly advanced phase is first visible
// master = controlling side (top level / bench), slave = the sequencer.
interface rgb_fade_sequencer_if #(
    parameter int unsigned PWM_INTERVAL = 1200
) ();
    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);

    logic          enable;
    logic          led_r;
    logic          led_g;
    logic          led_b;
    logic [DW-1:0] duty_r;
    logic [DW-1:0] duty_g;
    logic [DW-1:0] duty_b;
    logic [2:0]    phase;
    logic          phase_done;

    modport master (
        output enable,
        input  led_r, led_g, led_b, duty_r, duty_g, duty_b, phase, phase_done
    );

    modport slave (
        input  enable,
        output led_r, led_g, led_b, duty_r, duty_g, duty_b, phase, phase_done
    );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Six-phase HSV colour-wheel fader for an RGB LED.
// Owns the brightness-step prescaler, the per-channel duty registers and a
// shared PWM counter with per-period shadow duties.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : rgb_fade_sequencer_if.slave (enable in; LEDs, duties, phase,
//         phase_done out)
module rgb_fade_sequencer #(
    parameter int unsigned PWM_INTERVAL    = 1200,
    parameter int unsigned STEP_INTERVAL   = 12000,
    parameter int unsigned STEPS_PER_PHASE = 200
) (
    input  logic                clk,
    input  logic                rst,
    rgb_fade_sequencer_if.slave bus
);
    localparam int unsigned STEP_VAL = PWM_INTERVAL / STEPS_PER_PHASE;
    localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int unsigned PW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int unsigned SW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [DW-1:0] DMAX  = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] DSTEP = DW'(STEP_VAL);
    // Index 0 = red, 1 = green, 2 = blue.
    localparam logic [2:0][DW-1:0] DUTY_RST = {{DW{1'b0}}, {DW{1'b0}}, DMAX};

    if (PWM_INTERVAL % STEPS_PER_PHASE != 0) begin : g_bad_cfg
        $error("rgb_fade_sequencer: PWM_INTERVAL must be a multiple of STEPS_PER_PHASE");
    end

    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } phase_t;

    phase_t            phase_q, phase_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     step_q, step_d;
    logic [2:0][DW-1:0] duty_q, duty_d;
    logic              done_q, done_d;
    logic [CW-1:0]     pwm_cnt_q;
    logic [2:0][DW-1:0] shadow_q;

    logic [1:0]        ramp_ch;
    logic              ramp_up;
    logic [DW-1:0]     ramp_cur;
    logic              step_evt;
    logic              pwm_wrap;

    assign step_evt = bus.enable && (presc_q == PW'(STEP_INTERVAL - 1));
    assign pwm_wrap = (pwm_cnt_q == CW'(PWM_INTERVAL - 1));

    always_comb begin
        phase_d  = phase_q;
        presc_d  = presc_q;
        step_d   = step_q;
        duty_d   = duty_q;
        done_d   = 1'b0;
        ramp_ch  = 2'd1;
        ramp_up  = 1'b1;

        case (phase_q)
            PH_G_UP: begin ramp_ch = 2'd1; ramp_up = 1'b1; end
            PH_R_DN: begin ramp_ch = 2'd0; ramp_up = 1'b0; end
            PH_B_UP: begin ramp_ch = 2'd2; ramp_up = 1'b1; end
            PH_G_DN: begin ramp_ch = 2'd1; ramp_up = 1'b0; end
            PH_R_UP: begin ramp_ch = 2'd0; ramp_up = 1'b1; end
            PH_B_DN: begin ramp_ch = 2'd2; ramp_up = 1'b0; end
            default: ;
        endcase
        ramp_cur = duty_q[ramp_ch];

        if (bus.enable) begin
            presc_d = step_evt ? '0 : presc_q + 1'b1;
        end

        if (step_evt) begin
            if (step_q == SW'(STEPS_PER_PHASE - 1)) begin
                // Last step lands exactly on the end value regardless of rounding.
                duty_d[ramp_ch] = ramp_up ? DMAX : '0;
                step_d  = '0;
                done_d  = 1'b1;
                phase_d = (phase_q == PH_B_DN) ? PH_G_UP : phase_t'(phase_q + 3'd1);
            end else begin
                // Saturating ramp: never wraps outside 0..PWM_INTERVAL.
                if (ramp_up) begin
                    duty_d[ramp_ch] = (ramp_cur >= DMAX - DSTEP) ? DMAX : ramp_cur + DSTEP;
                end else begin
                    duty_d[ramp_ch] = (ramp_cur <= DSTEP) ? '0 : ramp_cur - DSTEP;
                end
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_G_UP;
            presc_q   <= '0;
            step_q    <= '0;
            duty_q    <= DUTY_RST;
            done_q    <= 1'b0;
            pwm_cnt_q <= '0;
            shadow_q  <= DUTY_RST;
        end else begin
            phase_q   <= phase_d;
            presc_q   <= presc_d;
            step_q    <= step_d;
            duty_q    <= duty_d;
            done_q    <= done_d;
            pwm_cnt_q <= pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
            // Shadow captures the pre-step duty, so a coincident step is
            // deferred by one full PWM period.
            if (pwm_wrap) begin
                shadow_q <= duty_q;
            end
        end
    end

    assign bus.led_r      = (DW'(pwm_cnt_q) < shadow_q[0]);
    assign bus.led_g      = (DW'(pwm_cnt_q) < shadow_q[1]);
    assign bus.led_b      = (DW'(pwm_cnt_q) < shadow_q[2]);
    assign bus.duty_r     = duty_q[0];
    assign bus.duty_g     = duty_q[1];
    assign bus.duty_b     = duty_q[2];
    assign bus.phase      = phase_q;
    assign bus.phase_done = done_q;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer with a closed-form reference:
// expected duties/phase are computed from the number of enabled clocks since
// reset; LEDs from a cycle count and a model of the per-period shadow.
module tb_rgb_fade_sequencer;
    localparam int unsigned PWM = 12;
    localparam int unsigned SI  = 4;
    localparam int unsigned SPP = 3;
    localparam int unsigned SV  = PWM / SPP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    // Reference state
    int unsigned n_en = 0;   // enabled edges since reset
    int unsigned cyc  = 0;   // edges since reset (PWM position)
    int unsigned sh_r = PWM, sh_g = 0, sh_b = 0;
    int unsigned done_m = 0;

    rgb_fade_sequencer_if #(.PWM_INTERVAL(PWM)) bus ();

    rgb_fade_sequencer #(
        .PWM_INTERVAL    (PWM),
        .STEP_INTERVAL   (SI),
        .STEPS_PER_PHASE (SPP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Colour wheel from the total number of brightness steps taken.
    function automatic void model_duty(input int unsigned n,
                                       output int unsigned r, output int unsigned g,
                                       output int unsigned b, output int unsigned ph);
        int unsigned s, k, up, dn;
        s  = n / SI;
        k  = s % SPP;
        ph = (s / SPP) % 6;
        up = k * SV;
        dn = PWM - k * SV;
        case (ph)
            0:       begin r = PWM; g = up;  b = 0;   end
            1:       begin r = dn;  g = PWM; b = 0;   end
            2:       begin r = 0;   g = PWM; b = up;  end
            3:       begin r = 0;   g = dn;  b = PWM; end
            4:       begin r = up;  g = 0;   b = PWM; end
            default: begin r = PWM; g = 0;   b = dn;  end
        endcase
    endfunction

    task automatic compare_all();
        int unsigned r, g, b, ph, pos;
        model_duty(n_en, r, g, b, ph);
        pos = cyc % PWM;
        check("phase",      32'(bus.phase),      ph);
        check("duty_r",     32'(bus.duty_r),     r);
        check("duty_g",     32'(bus.duty_g),     g);
        check("duty_b",     32'(bus.duty_b),     b);
        check("phase_done", 32'(bus.phase_done), done_m);
        check("led_r",      32'(bus.led_r),      (pos < sh_r) ? 1 : 0);
        check("led_g",      32'(bus.led_g),      (pos < sh_g) ? 1 : 0);
        check("led_b",      32'(bus.led_b),      (pos < sh_b) ? 1 : 0);
        check("duty_g_mult", 32'(bus.duty_g) % SV, 0);
    endtask

    // One clock with the given inputs; model advanced, then outputs checked.
    task automatic tick(input logic r, input logic e);
        int unsigned pr, pg, pb, pp, s0;
        @(negedge clk);
        rst        = r;
        bus.enable = e;
        @(posedge clk);
        if (r) begin
            n_en = 0; cyc = 0; done_m = 0;
            sh_r = PWM; sh_g = 0; sh_b = 0;
        end else begin
            if (cyc % PWM == PWM - 1) begin
                model_duty(n_en, pr, pg, pb, pp);
                sh_r = pr; sh_g = pg; sh_b = pb;
            end
            cyc++;
            done_m = 0;
            if (e) begin
                s0 = n_en / SI;
                n_en++;
                if ((n_en / SI != s0) && ((n_en / SI) % SPP == 0)) done_m = 1;
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        bus.enable = 1'b0;

        // Reset and first phase with enable held high
        tick(1'b1, 1'b1);
        check("rst_led_r", 32'(bus.led_r), 1);
        check("rst_led_g", 32'(bus.led_g), 0);
        for (int i = 1; i <= 80; i++) begin
            tick(1'b0, 1'b1);
            if (i == 4)  check("g_at4", 32'(bus.duty_g), 4);
            if (i == 8)  check("g_at8", 32'(bus.duty_g), 8);
            if (i == 12) begin
                check("g_at12", 32'(bus.duty_g), 12);
                check("ph_at12", 32'(bus.phase), 1);
                check("done_at12", 32'(bus.phase_done), 1);
            end
            if (i == 13) check("done_at13", 32'(bus.phase_done), 0);
            if (i == 72) begin
                check("ph_at72", 32'(bus.phase), 0);
                check("r_at72", 32'(bus.duty_r), 12);
                check("g_at72", 32'(bus.duty_g), 0);
            end
        end

        // Freeze: enable dropped after edge 6 for 10 cycles
        tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++)  tick(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            check("frz_g", 32'(bus.duty_g), 4);
        end
        tick(1'b0, 1'b1);
        check("resume1_g", 32'(bus.duty_g), 4);
        tick(1'b0, 1'b1);
        check("resume2_g", 32'(bus.duty_g), 8);

        // Reset in the middle of phase 3
        for (int i = 0; i < 100 && bus.phase != 3'd3; i++) tick(1'b0, 1'b1);
        check("reach_ph3", 32'(bus.phase), 3);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("mid_rst_ph", 32'(bus.phase), 0);
        check("mid_rst_r",  32'(bus.duty_r), 12);
        check("mid_rst_done", 32'(bus.phase_done), 0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);

        // Random enable pattern with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
